// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB2 shared types, slave FSM encoding and byte-lane strobe helper
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'd0,
      HRESP_ERROR = 2'd1,
      HRESP_RETRY = 2'd2,
      HRESP_SPLIT = 2'd3
   } hresp_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_t;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_t;

   typedef enum logic [1:0] {
      ST_READY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ERR1  = 2'd2,
      ST_ERR2  = 2'd3
   } slv_state_t;

   // Transfer captured in the address phase and acted on in the data phase
   typedef struct packed {
      logic       valid;
      logic       write;
      logic [2:0] size;
      logic [1:0] off;
   } pend_t;

   // Byte lanes touched by a transfer of the given size at the given byte offset
   function automatic logic [3:0] strb(input logic [2:0] hsize, input logic [1:0] offset);
      logic [3:0] s;
      s = 4'h0;
      case (hsize)
         HSIZE_BYTE: s = 4'b0001 << offset;
         HSIZE_HALF: s = 4'b0011 << offset;
         HSIZE_WORD: s = 4'b1111;
         default:    s = 4'h0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ahb_sram_bytemem.sv
// rtl/ahb_sram_bytemem.sv - word-organised SRAM with per-byte write strobes
module ahb_sram_bytemem #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   // Synchronous byte-lane write; lanes without a strobe keep their contents
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i[b]) begin
            mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB2 slave fronting an on-chip SRAM with wait states and ERROR response
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int unsigned MEM_DEPTH   = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HBURST,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   output logic        HREADY,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA
);

   localparam int unsigned AW       = $clog2(MEM_DEPTH);
   localparam bit          HAS_WAIT = (WAIT_STATES != 0);
   localparam logic [3:0]  WS_LOAD  = 4'(WAIT_STATES - 1);

   slv_state_t    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   pend_t         pend_q, pend_d;
   logic [AW-1:0] pend_idx_q, pend_idx_d;

   logic          active;
   logic          addr_err;
   logic          size_err;
   logic          req_err;
   logic [3:0]    mem_we;
   logic [31:0]   mem_rdata;

   // Addresses are taken beat by beat, so the burst type carries no information here
   logic unused_hburst;
   assign unused_hburst = ^HBURST;

   // Address-phase decode: is this an active transfer, and is it illegal
   always_comb begin
      active   = HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
      // BASE_ADDR is aligned to the memory size, so the window check is a tag compare
      addr_err = (HADDR[31:AW+2] != BASE_ADDR[31:AW+2]);
      size_err = (HSIZE > 3'd2)
              || (HSIZE == HSIZE_HALF && HADDR[0])
              || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);
      req_err  = active && (addr_err || size_err);
   end

   // FSM state register
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= ST_READY;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: READY and ERR2 both sample a new address phase
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_READY, ST_ERR2: begin
            if (!active)      state_d = ST_READY;
            else if (req_err) state_d = ST_ERR1;
            else if (HAS_WAIT) state_d = ST_WAIT;
            else              state_d = ST_READY;
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_READY;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_READY;
      endcase
   end

   // FSM outputs; read data is presented only in the completing cycle of a legal read
   always_comb begin
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      HRDATA = 32'h0;
      case (state_q)
         ST_READY: begin
            if (pend_q.valid && !pend_q.write) HRDATA = mem_rdata;
         end
         ST_WAIT: HREADY = 1'b0;
         ST_ERR1: begin
            HREADY = 1'b0;
            HRESP  = HRESP_ERROR;
         end
         ST_ERR2: HRESP = HRESP_ERROR;
         default: ;
      endcase
   end

   // Next values of the wait counter and the captured transfer
   always_comb begin
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      pend_idx_d = pend_idx_q;
      if (HREADY) begin
         // Errored, idle and busy cycles leave nothing pending for the data phase
         pend_d.valid = active && !req_err;
         pend_d.write = HWRITE;
         pend_d.size  = HSIZE;
         pend_d.off   = HADDR[1:0];
         pend_idx_d   = HADDR[AW+1:2];
         if (active && !req_err && HAS_WAIT) cnt_d = WS_LOAD;
      end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   // Wait counter and address-phase register
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         cnt_q      <= 4'd0;
         pend_q     <= '0;
         pend_idx_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         pend_idx_q <= pend_idx_d;
      end
   end

   // Write lanes commit on the edge that ends a legal write data phase
   always_comb begin
      mem_we = 4'h0;
      if (HREADY && pend_q.valid && pend_q.write) mem_we = strb(pend_q.size, pend_q.off);
   end

   ahb_sram_bytemem #(
      .DEPTH (MEM_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (HCLK),
      .we_i    (mem_we),
      .waddr_i (pend_idx_q),
      .wdata_i (HWDATA),
      .raddr_i (pend_idx_q),
      .rdata_o (mem_rdata)
   );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - randomized self-checking bench for ahb_sram_slave against a transfer-level model
module tb_ahb_sram_slave;

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_BUSY = 2'd1;
   localparam logic [1:0] T_NS   = 2'd2;
   localparam logic [1:0] T_SEQ  = 2'd3;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } beat_t;

   typedef struct {
      logic        rdy;
      logic        e_rdy;
      logic [1:0]  resp;
      logic [1:0]  e_resp;
      logic [31:0] rd;
      logic [31:0] e_rd;
   } cyc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel;
   logic        tgt;
   logic [1:0]  htrans;
   logic [2:0]  hburst;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hsel0, hsel3;
   logic        hready0, hready3;
   logic [1:0]  hresp0, hresp3;
   logic [31:0] hrdata0, hrdata3;
   logic        o_rdy;
   logic [1:0]  o_resp;
   logic [31:0] o_rd;

   int          n_assert = 0;
   int          n_fail   = 0;
   cyc_t        cq[$];
   logic [31:0] rdq[$];
   int          low_cnt;
   int          ncyc;
   logic [31:0] mdl [0:1][0:255];

   always #5 clk = ~clk;

   assign hsel0  = hsel & ~tgt;
   assign hsel3  = hsel & tgt;
   assign o_rdy  = tgt ? hready3 : hready0;
   assign o_resp = tgt ? hresp3 : hresp0;
   assign o_rd   = tgt ? hrdata3 : hrdata0;

   ahb_sram_slave #(.MEM_DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HTRANS(htrans), .HBURST(hburst),
      .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
      .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0)
   );

   ahb_sram_slave #(.MEM_DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HTRANS(htrans), .HBURST(hburst),
      .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
      .HREADY(hready3), .HRESP(hresp3), .HRDATA(hrdata3)
   );

   function automatic beat_t mk(input logic s, input logic [1:0] t, input logic w,
                                input logic [2:0] z, input logic [31:0] a, input logic [31:0] d);
      beat_t b;
      b.sel = s; b.trans = t; b.wr = w; b.size = z; b.addr = a; b.wdata = d;
      return b;
   endfunction

   function automatic bit b_active(input beat_t b);
      return b.sel && (b.trans == T_NS || b.trans == T_SEQ);
   endfunction

   function automatic bit b_err(input beat_t b);
      bit bad;
      bad = (b.addr >= 32'h400) || (b.size > 3'd2)
         || (b.size == 3'd1 && b.addr[0]) || (b.size == 3'd2 && b.addr[1:0] != 2'b00);
      return b_active(b) && bad;
   endfunction

   task automatic drive_addr(input beat_t b);
      hsel = b.sel; htrans = b.trans; hwrite = b.wr; hsize = b.size; haddr = b.addr;
   endtask

   task automatic model_write(input beat_t b);
      int nb;
      int lane;
      nb = 1 << b.size;
      for (int j = 0; j < nb; j++) begin
         lane = int'(b.addr[1:0]) + j;
         mdl[tgt][b.addr[9:2]][lane*8 +: 8] = b.wdata[lane*8 +: 8];
      end
   endtask

   // Pipelined master: each beat's data phase length comes from the model, not the DUT
   task automatic run_seq(input beat_t q_in[$]);
      beat_t q[$];
      int    n;
      int    len;
      bit    act;
      bit    er;
      q = q_in;
      n = q.size();
      q.push_back(mk(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
      cq.delete(); rdq.delete(); low_cnt = 0; ncyc = 0;
      drive_addr(q[0]);
      @(posedge clk); #1;
      for (int i = 0; i <= n; i++) begin
         act = b_active(q[i]);
         er  = b_err(q[i]);
         len = !act ? 1 : (er ? 2 : 1 + (tgt ? 3 : 0));
         hwdata = q[i].wdata;
         drive_addr(q[(i < n) ? i + 1 : n]);
         for (int k = 0; k < len; k++) begin
            cyc_t c;
            @(negedge clk);
            c.rdy = o_rdy; c.resp = o_resp; c.rd = o_rd;
            c.e_rdy  = (k == len - 1);
            c.e_resp = er ? 2'd1 : 2'd0;
            c.e_rd   = (k == len - 1 && act && !er && !q[i].wr) ? mdl[tgt][q[i].addr[9:2]] : 32'h0;
            cq.push_back(c);
            if (!o_rdy) low_cnt++;
            if (k == len - 1) rdq.push_back(o_rd);
            if (i < n) ncyc++;
            @(posedge clk); #1;
         end
         if (act && !er && q[i].wr) model_write(q[i]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_assert++;
      if (hready0 !== 1'b1 || hresp0 !== 2'd0 || hrdata0 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_dut0: got rdy=%b resp=%0d rdata=%h, expected 1/0/00000000", hready0, hresp0, hrdata0);
      end
      n_assert++;
      if (hready3 !== 1'b1 || hresp3 !== 2'd0 || hrdata3 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_dut3: got rdy=%b resp=%0d rdata=%h, expected 1/0/00000000", hready3, hresp3, hrdata3);
      end
      rst = 1'b0;
      @(negedge clk);
      n_assert++;
      if (hready0 !== 1'b1 || hresp0 !== 2'd0 || hready3 !== 1'b1 || hresp3 !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_release: got rdy0=%b resp0=%0d rdy3=%b resp3=%0d, expected 1/0/1/0", hready0, hresp0, hready3, hresp3);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ws0_b2b();
      beat_t q[$];
      tgt = 1'b0; hburst = 3'd0;
      q.push_back(mk(1'b1, T_NS, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
      q.push_back(mk(1'b1, T_NS, 1'b0, 3'd2, 32'h10, 32'h0));
      run_seq(q);
      foreach (cq[j]) begin
         n_assert++;
         if (cq[j].rdy !== cq[j].e_rdy || cq[j].resp !== cq[j].e_resp || cq[j].rd !== cq[j].e_rd) begin
            n_fail++;
            $display("FAIL ws0_b2b cyc %0d: got rdy=%b resp=%0d rdata=%h, expected rdy=%b resp=%0d rdata=%h",
                     j, cq[j].rdy, cq[j].resp, cq[j].rd, cq[j].e_rdy, cq[j].e_resp, cq[j].e_rd);
         end
      end
      n_assert++;
      if (low_cnt !== 0) begin
         n_fail++;
         $display("FAIL ws0_b2b_ready_low: got %0d low cycles, expected 0", low_cnt);
      end
      n_assert++;
      if (rdq[1] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL ws0_b2b_readback: got %h, expected deadbeef", rdq[1]);
      end
   endtask

   task automatic test_byte_lane();
      beat_t q[$];
      tgt = 1'b0;
      q.push_back(mk(1'b1, T_NS, 1'b1, 3'd2, 32'h20, 32'h11223344));
      q.push_back(mk(1'b1, T_NS, 1'b1, 3'd0, 32'h21, 32'h0000AB00));
      q.push_back(mk(1'b1, T_NS, 1'b0, 3'd2, 32'h20, 32'h0));
      run_seq(q);
      foreach (cq[j]) begin
         n_assert++;
         if (cq[j].rdy !== cq[j].e_rdy || cq[j].resp !== cq[j].e_resp || cq[j].rd !== cq[j].e_rd) begin
            n_fail++;
            $display("FAIL byte_lane cyc %0d: got rdy=%b resp=%0d rdata=%h, expected rdy=%b resp=%0d rdata=%h",
                     j, cq[j].rdy, cq[j].resp, cq[j].rd, cq[j].e_rdy, cq[j].e_resp, cq[j].e_rd);
         end
      end
      n_assert++;
      if (rdq[2] !== 32'h1122AB44) begin
         n_fail++;
         $display("FAIL byte_lane_readback: got %h, expected 1122ab44", rdq[2]);
      end
   endtask

   task automatic test_wait_states();
      beat_t q[$];
      tgt = 1'b1; hburst = 3'd3;
      for (int i = 0; i < 4; i++) begin
         q.push_back(mk(1'b1, (i == 0) ? T_NS : T_SEQ, 1'b1, 3'd2, 32'h30 + 32'(4 * i), $urandom));
      end
      run_seq(q);
      q.delete();
      q.push_back(mk(1'b1, T_NS, 1'b0, 3'd2, 32'h30, 32'h0));
      run_seq(q);
      foreach (cq[j]) begin
         n_assert++;
         if (cq[j].rdy !== cq[j].e_rdy || cq[j].resp !== cq[j].e_resp || cq[j].rd !== cq[j].e_rd) begin
            n_fail++;
            $display("FAIL ws3_single cyc %0d: got rdy=%b resp=%0d rdata=%h, expected rdy=%b resp=%0d rdata=%h",
                     j, cq[j].rdy, cq[j].resp, cq[j].rd, cq[j].e_rdy, cq[j].e_resp, cq[j].e_rd);
         end
      end
      n_assert++;
      if (low_cnt !== 3) begin
         n_fail++;
         $display("FAIL ws3_single_low: got %0d low cycles, expected 3", low_cnt);
      end
      q.delete();
      for (int i = 0; i < 4; i++) begin
         q.push_back(mk(1'b1, (i == 0) ? T_NS : T_SEQ, 1'b0, 3'd2, 32'h30 + 32'(4 * i), 32'h0));
      end
      run_seq(q);
      foreach (cq[j]) begin
         n_assert++;
         if (cq[j].rdy !== cq[j].e_rdy || cq[j].resp !== cq[j].e_resp || cq[j].rd !== cq[j].e_rd) begin
            n_fail++;
            $display("FAIL ws3_incr4 cyc %0d: got rdy=%b resp=%0d rdata=%h, expected rdy=%b resp=%0d rdata=%h",
                     j, cq[j].rdy, cq[j].resp, cq[j].rd, cq[j].e_rdy, cq[j].e_resp, cq[j].e_rd);
         end
      end
      n_assert++;
      if (ncyc !== 16 || low_cnt !== 12) begin
         n_fail++;
         $display("FAIL ws3_incr4_len: got %0d cycles (%0d low), expected 16 (12 low)", ncyc, low_cnt);
      end
   endtask

   task automatic test_errors();
      beat_t q[$];
      int    nerr;
      hburst = 3'd0;
      for (int t = 0; t < 2; t++) begin
         tgt = t[0];
         q.delete();
         q.push_back(mk(1'b1, T_NS, 1'b1, 3'd2, 32'h00, 32'hCAFEF00D));
         q.push_back(mk(1'b1, T_NS, 1'b1, 3'd2, 32'h04, 32'h01020304));
         q.push_back(mk(1'b1, T_NS, 1'b1, 3'd2, 32'h400, 32'hFFFFFFFF));
         q.push_back(mk(1'b1, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
         q.push_back(mk(1'b1, T_NS, 1'b1, 3'd2, 32'h02, 32'h55555555));
         q.push_back(mk(1'b1, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
         q.push_back(mk(1'b1, T_NS, 1'b1, 3'd1, 32'h05, 32'hAAAAAAAA));
         q.push_back(mk(1'b1, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
         q.push_back(mk(1'b1, T_NS, 1'b0, 3'd3, 32'h04, 32'h0));
         q.push_back(mk(1'b1, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
         q.push_back(mk(1'b1, T_NS, 1'b0, 3'd2, 32'h00, 32'h0));
         q.push_back(mk(1'b1, T_NS, 1'b0, 3'd2, 32'h04, 32'h0));
         run_seq(q);
         nerr = 0;
         foreach (cq[j]) begin
            if (cq[j].resp == 2'd1) nerr++;
            n_assert++;
            if (cq[j].rdy !== cq[j].e_rdy || cq[j].resp !== cq[j].e_resp || cq[j].rd !== cq[j].e_rd) begin
               n_fail++;
               $display("FAIL errors ws%0d cyc %0d: got rdy=%b resp=%0d rdata=%h, expected rdy=%b resp=%0d rdata=%h",
                        3 * t, j, cq[j].rdy, cq[j].resp, cq[j].rd, cq[j].e_rdy, cq[j].e_resp, cq[j].e_rd);
            end
         end
         n_assert++;
         if (nerr !== 8) begin
            n_fail++;
            $display("FAIL errors_count ws%0d: got %0d ERROR cycles, expected 8", 3 * t, nerr);
         end
         n_assert++;
         if (rdq[10] !== 32'hCAFEF00D || rdq[11] !== 32'h01020304) begin
            n_fail++;
            $display("FAIL errors_mem_unchanged ws%0d: got %h %h, expected cafef00d 01020304", 3 * t, rdq[10], rdq[11]);
         end
      end
   endtask

   task automatic test_busy_idle();
      beat_t q[$];
      tgt = 1'b0; hburst = 3'd1;
      q.push_back(mk(1'b1, T_NS, 1'b1, 3'd2, 32'h48, 32'h48484848));
      run_seq(q);
      q.delete();
      q.push_back(mk(1'b1, T_NS,   1'b1, 3'd2, 32'h40, 32'hA0A0A0A0));
      q.push_back(mk(1'b1, T_BUSY, 1'b1, 3'd2, 32'h44, 32'hBAD1BAD1));
      q.push_back(mk(1'b1, T_SEQ,  1'b1, 3'd2, 32'h44, 32'hB0B0B0B0));
      q.push_back(mk(1'b1, T_IDLE, 1'b1, 3'd2, 32'h48, 32'hBAD2BAD2));
      q.push_back(mk(1'b1, T_NS,   1'b0, 3'd2, 32'h40, 32'h0));
      q.push_back(mk(1'b1, T_NS,   1'b0, 3'd2, 32'h44, 32'h0));
      q.push_back(mk(1'b1, T_NS,   1'b0, 3'd2, 32'h48, 32'h0));
      run_seq(q);
      foreach (cq[j]) begin
         n_assert++;
         if (cq[j].rdy !== cq[j].e_rdy || cq[j].resp !== cq[j].e_resp || cq[j].rd !== cq[j].e_rd) begin
            n_fail++;
            $display("FAIL busy_idle cyc %0d: got rdy=%b resp=%0d rdata=%h, expected rdy=%b resp=%0d rdata=%h",
                     j, cq[j].rdy, cq[j].resp, cq[j].rd, cq[j].e_rdy, cq[j].e_resp, cq[j].e_rd);
         end
      end
      n_assert++;
      if (low_cnt !== 0 || rdq[4] !== 32'hA0A0A0A0 || rdq[5] !== 32'hB0B0B0B0 || rdq[6] !== 32'h48484848) begin
         n_fail++;
         $display("FAIL busy_idle_mem: got low=%0d %h %h %h, expected 0 a0a0a0a0 b0b0b0b0 48484848",
                  low_cnt, rdq[4], rdq[5], rdq[6]);
      end
   endtask

   task automatic test_reset_mid_wait();
      beat_t q[$];
      tgt = 1'b1; hburst = 3'd0;
      q.push_back(mk(1'b1, T_NS, 1'b1, 3'd2, 32'h60, 32'h60606060));
      run_seq(q);
      drive_addr(mk(1'b1, T_NS, 1'b1, 3'd2, 32'h60, 32'h0));
      @(posedge clk); #1;
      drive_addr(mk(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
      hwdata = 32'hBAD0BAD0;
      @(negedge clk);
      n_assert++;
      if (o_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wait_stall: got rdy=%b, expected 0", o_rdy);
      end
      #2 rst = 1'b1;
      #1;
      n_assert++;
      if (o_rdy !== 1'b1 || o_resp !== 2'd0 || o_rd !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_wait_async: got rdy=%b resp=%0d rdata=%h, expected 1/0/00000000", o_rdy, o_resp, o_rd);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      q.push_back(mk(1'b1, T_NS, 1'b0, 3'd2, 32'h60, 32'h0));
      run_seq(q);
      n_assert++;
      if (rdq[0] !== 32'h60606060) begin
         n_fail++;
         $display("FAIL rst_wait_dropped: got %h, expected 60606060", rdq[0]);
      end
   endtask

   task automatic test_random();
      beat_t q[$];
      beat_t b;
      int    sz;
      for (int t = 0; t < 2; t++) begin
         tgt = t[0];
         hburst = 3'($urandom_range(0, 7));
         q.delete();
         for (int i = 0; i < 16; i++) begin
            q.push_back(mk(1'b1, T_NS, 1'b1, 3'd2, 32'h80 + 32'(4 * i), $urandom));
         end
         for (int i = 0; i < 60; i++) begin
            sz = $urandom_range(0, 7);
            b = mk($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   (sz >= 6) ? 3'd3 : 3'(sz % 3),
                   ($urandom_range(0, 19) == 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                                : 32'h80 + 32'($urandom_range(0, 63)),
                   $urandom);
            q.push_back(b);
            if (b_err(b)) q.push_back(mk(1'b1, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
         end
         run_seq(q);
         foreach (cq[j]) begin
            n_assert++;
            if (cq[j].rdy !== cq[j].e_rdy || cq[j].resp !== cq[j].e_resp || cq[j].rd !== cq[j].e_rd) begin
               n_fail++;
               $display("FAIL random ws%0d cyc %0d: got rdy=%b resp=%0d rdata=%h, expected rdy=%b resp=%0d rdata=%h",
                        3 * t, j, cq[j].rdy, cq[j].resp, cq[j].rd, cq[j].e_rdy, cq[j].e_resp, cq[j].e_rd);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; tgt = 1'b0; hburst = 3'd0; hwdata = 32'h0;
      drive_addr(mk(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
      test_reset();
      test_ws0_b2b();
      test_byte_lane();
      test_wait_states();
      test_errors();
      test_busy_idle();
      test_reset_mid_wait();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB2 responder fronting a word-organised on-chip SRAM. It decodes master address/control phases, inserts a configurable number of wait states, performs byte/halfword/word writes and reads, and issues the two-cycle ERROR response for illegal accesses. It is the slave-side counterpart driven by the master agent through the shared AHB interface, so the bench can run the master driver against real RTL.

## Interface

Parameters:
- MEM_DEPTH, 256: number of 32-bit words; power of two, 4..4096.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to MEM_DEPTH*4.
- WAIT_STATES, 0: HREADY-low cycles per OKAY data phase, 0..15.

Ports (one clock; reset is asynchronous and active-high):
- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  asynchronous active-high reset.
- HSEL  in  1  slave select, qualifies address phase.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HBURST  in  3  accepted and ignored; addresses are taken per beat.
- HSIZE  in  3  0=byte, 1=halfword, 2=word; >2 is illegal.
- HWRITE  in  1  1=write.
- HADDR  in  32  byte address.
- HWDATA  in  32  write data, valid in data phase.
- HREADY  out  1  transfer done / address phase sampled when high.
- HRESP  out  2  OKAY=0, ERROR=1 (RETRY/SPLIT never issued).
- HRDATA  out  32  read data, valid in last data-phase cycle.

## Operation

- Address phase sampled on rising HCLK when HREADY=1. Active transfer: HSEL=1 and HTRANS in {NONSEQ, SEQ}. IDLE, BUSY, or HSEL=0: no data phase work, zero-wait OKAY.
- Captured per active transfer: word index, byte offset HADDR[1:0], HSIZE, HWRITE, error flag.
- Error flag set if any: HADDR outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*4); HSIZE>2; HSIZE=1 with HADDR[0]=1; HSIZE=2 with HADDR[1:0]!=0.
- FSM states:
  - READY: HREADY=1, HRESP=OKAY. Active legal transfer → WAIT if WAIT_STATES>0, else stays READY and completes in the next cycle. Active illegal transfer → ERR1.
  - WAIT: HREADY=0, HRESP=OKAY; 4-bit counter loaded with WAIT_STATES-1, decrements; at 0 → READY, which is the completing cycle.
  - ERR1: HREADY=0, HRESP=ERROR → ERR2.
  - ERR2: HREADY=1, HRESP=ERROR; address phase is sampled normally (master must drive IDLE) → READY/WAIT/ERR1 per sampled transfer.
- Writes: byte-lane strobes from HSIZE/offset (byte: 1<<off; half: 3<<off; word: 4'hF). HWDATA lanes are committed on the edge ending the data phase (HREADY=1). Unselected lanes are unchanged. Erroring transfers never write.
- Reads: HRDATA = full stored word (all lanes) during the completing cycle; 0 in all other cycles and for errored reads.
- Read following a write to the same word: the read returns the newly written data, since the commit edge precedes the read data phase.

## Timing

- Reset values: HREADY=1, HRESP=OKAY, HRDATA=0, FSM=READY, counter=0, pending transfer cleared. Memory contents are not reset.
- OKAY latency: data phase = 1+WAIT_STATES cycles; pipelined: the next address phase overlaps the completing cycle, giving back-to-back throughput of one beat per 1+WAIT_STATES cycles.
- ERROR: always exactly 2 data-phase cycles regardless of WAIT_STATES.
- HRESET asserted mid-transfer: outputs return to reset values asynchronously and the pending write is dropped.
- BUSY within a burst: OKAY, no memory access, no wait states.

## Structure

- Shared package ahb_pkg: htrans_t, hresp_t, hsize_t, hburst_t enums, and a lane-strobe function strb(hsize, offset) → 4 bits.
- Sub-module ahb_sram_bytemem: MEM_DEPTH×32 array, 4 byte-write strobes, synchronous write, combinational read by index.
- Top holds the address-phase register, FSM, wait counter, and error decode.

## Test plan

- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 back-to-back → HREADY never low, HRDATA=0xDEADBEEF in read completing cycle.
- Byte write 0xAB to lane 1 (HSIZE=0, HADDR=0x21, HWDATA=0x0000AB00) over prior word 0x11223344 @0x20 → read returns 0x1122AB44.
- WAIT_STATES=3: word read → HREADY low exactly 3 cycles, data valid on 4th cycle; 4-beat INCR takes 16 cycles.
- Write @BASE_ADDR+MEM_DEPTH*4 and word access @0x02 → each gets HREADY 0→1 with HRESP=ERROR for 2 cycles; memory unchanged.
- NONSEQ, BUSY, SEQ, IDLE sequence → BUSY/IDLE cycles get zero-wait OKAY; only 2 memory accesses occur.
- HRESET pulsed during WAIT of a write → HREADY=1 and HRESP=OKAY immediately; target word unchanged.
